foo_intf_demux: RTL
===================

FOO_INTF_DEMUX -- requirements
Module: foo_intf_demux

Interface
REQ-001 Parameter N, default 4, number of foo_intf lanes driven.
REQ-002 Parameter IDXW, default 8, width of the lane index.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous and active-low.
REQ-005 in_valid  input  1  upstream request present.
REQ-006 in_ready  output  1  request accepted on clk edge when in_valid && in_ready.
REQ-007 in_idx  input  IDXW  non-constant target lane index.
REQ-008 in_a  input  1  payload bit, delivered to the selected lane's a field.
REQ-009 lane_valid  output  N  per-lane valid; bit i drives foos[i].
REQ-010 lane_a  output  N  per-lane payload; bit i is foos[i].a.
REQ-011 lane_ready  input  N  per-lane ready from consumer i.
REQ-012 err_oor  output  1  one-cycle pulse for an accepted out-of-range index.
REQ-013 err_cnt  output  8  count of out-of-range drops.

Function
REQ-014 The block SHALL convert a runtime index into constant per-lane signals, so no downstream logic needs a non-constant select into an interface array.
REQ-015 States: EMPTY (no held request) and HOLD (one request held for lane sel_q).
REQ-016 in_ready SHALL be 1 in EMPTY and SHALL equal lane_ready[sel_q] in HOLD; it is combinational from lane_ready.
REQ-017 Accepting with in_idx < N: capture sel_q = in_idx and a_q = in_a; next state HOLD.
REQ-018 Accepting with in_idx >= N, compared at full IDXW width with no truncation: drop the request, assert err_oor for exactly the next cycle, and leave lane_* unchanged.
REQ-019 In HOLD, lane_valid SHALL be one-hot at bit sel_q and lane_a[sel_q] = a_q; all other bits SHALL be 0.
REQ-020 lane_valid and lane_a SHALL be driven directly from registers, with no combinational path from in_*.
REQ-021 Latency: a request accepted at edge k SHALL appear on lane_valid after edge k, i.e. in the following cycle.
REQ-022 A held request SHALL remain stable until lane_ready[sel_q] = 1; the other lanes' ready inputs are ignored.
REQ-023 If a lane handshake and a new accept occur on the same edge, the block SHALL stay in HOLD with the new sel_q/a_q, giving zero bubbles.
REQ-024 If a lane handshake occurs with no new accept, or the new request is out of range, the next state SHALL be EMPTY.
REQ-025 A sustained throughput of one request per cycle SHALL be achieved when the target lane is always ready.
REQ-026 N SHALL be between 1 and 2**IDXW inclusive; when N = 2**IDXW, err_oor SHALL never assert.

Reset
REQ-027 While rst_n = 0, all outputs SHALL clear immediately: state EMPTY, lane_valid = 0, lane_a = 0, err_oor = 0, err_cnt = 0, sel_q = 0, a_q = 0.
REQ-028 In-flight held data at reset assertion SHALL be discarded; after release, in_ready = 1 in the first cycle.
REQ-029 Reset release SHALL be synchronised externally; the block SHALL have no internal reset synchroniser.

Configuration
REQ-030 Macro FOO_INTF_DEMUX_ERRCNT_EN defined: err_cnt SHALL increment by 1 on each err_oor pulse and saturate at 255.
REQ-031 Macro FOO_INTF_DEMUX_ERRCNT_EN undefined: the counter logic SHALL be absent and err_cnt SHALL be tied to 0; err_oor behaviour is unchanged.

Verification
REQ-032 Reset, then in_idx=2, in_a=1, lane_ready=4'b0100 -> lane_valid=4'b0100 and lane_a=4'b0100 in the next cycle; EMPTY after the handshake.
REQ-033 Back-to-back idx 0,1,2,3 with lane_ready=4'hF -> lane_valid sequence 0001, 0010, 0100, 1000 on consecutive cycles; in_ready held at 1 throughout.
REQ-034 idx=3 with lane_ready=4'b0111 for 5 cycles -> lane_valid=4'b1000 held stable and in_ready=0; raising lane_ready[3] completes the transfer.
REQ-035 in_idx=8'd4, then 8'd255 (N=4) -> two err_oor pulses, lane_valid stays 0; err_cnt=2 with the macro defined, 0 without it.
REQ-036 rst_n driven low mid-cycle while in HOLD on lane 1 -> lane_valid=0 immediately without waiting for a clk edge; in_ready=1 after release.
REQ-037 300 out-of-range requests with the macro defined -> err_cnt saturates at 255.

Source files
------------

// File: rtl/foo_intf_demux_if.sv
// Purpose: bundles the upstream request handshake and the per-lane outputs of foo_intf_demux.
// Ports: in_valid/in_ready/in_idx/in_a (upstream), lane_valid/lane_a/lane_ready (per lane), err_oor/err_cnt (status).
// Modports: slave = demux side, master = upstream producer / lane consumers (testbench side).
interface foo_intf_demux_if #(
    parameter int N    = 4,
    parameter int IDXW = 8
);
    logic            in_valid;
    logic            in_ready;
    logic [IDXW-1:0] in_idx;
    logic            in_a;
    logic [N-1:0]    lane_valid;
    logic [N-1:0]    lane_a;
    logic [N-1:0]    lane_ready;
    logic            err_oor;
    logic [7:0]      err_cnt;

    modport slave (
        input  in_valid,
        input  in_idx,
        input  in_a,
        input  lane_ready,
        output in_ready,
        output lane_valid,
        output lane_a,
        output err_oor,
        output err_cnt
    );

    modport master (
        output in_valid,
        output in_idx,
        output in_a,
        output lane_ready,
        input  in_ready,
        input  lane_valid,
        input  lane_a,
        input  err_oor,
        input  err_cnt
    );
endinterface

// File: rtl/foo_intf_demux.sv
// Purpose: turns a runtime lane index into constant per-lane valid/payload bits (one-deep skid-free holding stage).
// Latency: request accepted on edge k appears on lane_valid in cycle k+1; one request per cycle when the target lane is ready.
// Backpressure: in_ready is 1 when empty, else follows lane_ready of the held lane; other lanes' ready are ignored.
// Ports: clk, rst_n (async active-low, externally synchronised), bus (foo_intf_demux_if.slave).
// Optional: define FOO_INTF_DEMUX_ERRCNT_EN to build the saturating 8-bit out-of-range drop counter (err_cnt); otherwise err_cnt = 0.
module foo_intf_demux #(
    parameter int N    = 4,   // 1 .. 2**IDXW
    parameter int IDXW = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    foo_intf_demux_if.slave   bus
);
    localparam int SELW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {
        EMPTY = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t           state;
    logic [SELW-1:0]  sel_q;
    logic             a_q;
    logic [N-1:0]     lane_valid_q;
    logic             err_oor_q;

    logic             in_rdy;
    logic             accept;
    logic             oor;
    logic             lane_hs;
    logic [N-1:0]     idx_onehot;

    // Only the held lane's ready matters; in EMPTY the stage can always take a request.
    assign lane_hs = (state == HOLD) && bus.lane_ready[sel_q];
    assign in_rdy  = (state == EMPTY) || bus.lane_ready[sel_q];
    assign accept  = bus.in_valid && in_rdy;

    // Compare one bit wider than the index so N = 2**IDXW is representable
    // and no index can ever be out of range in that configuration.
    assign oor = {1'b0, bus.in_idx} >= (IDXW+1)'(N);

    always_comb begin
        idx_onehot = '0;
        for (int i = 0; i < N; i++) begin
            if (bus.in_idx == IDXW'(i)) begin
                idx_onehot[i] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= EMPTY;
            sel_q        <= '0;
            a_q          <= 1'b0;
            lane_valid_q <= '0;
            err_oor_q    <= 1'b0;
        end else begin
            err_oor_q <= accept && oor;
            if (accept && !oor) begin
                // Covers both a fresh accept from EMPTY and a same-edge
                // handshake + accept, so the lane side sees no bubble.
                state        <= HOLD;
                sel_q        <= bus.in_idx[SELW-1:0];
                a_q          <= bus.in_a;
                lane_valid_q <= idx_onehot;
            end else if (lane_hs) begin
                // Handshake with nothing new (or the new one was dropped).
                state        <= EMPTY;
                lane_valid_q <= '0;
            end
        end
    end

    assign bus.in_ready   = in_rdy;
    assign bus.lane_valid = lane_valid_q;
    // Both terms are flops, so lane_a has no path from the in_* inputs.
    assign bus.lane_a     = lane_valid_q & {N{a_q}};
    assign bus.err_oor    = err_oor_q;

`ifdef FOO_INTF_DEMUX_ERRCNT_EN
    logic [7:0] err_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= 8'd0;
        end else if (err_oor_q && (err_cnt_q != 8'hFF)) begin
            err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign bus.err_cnt = err_cnt_q;
`else
    assign bus.err_cnt = 8'd0;
`endif

endmodule
